// File: rtl/ms_timer_pkg.sv
// Shared types and defaults for the millisecond timer family.
// Holds the countdown state encoding and the default counter width.
package ms_timer_pkg;

    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSED
    } state_t;

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector for the 1 ms tick strobe. A strobe held high for
// several cycles produces exactly one tickRise.
module tick_edge_detect (
    input  logic pulseClk,
    input  logic rst_n,
    input  logic tickIn,
    output logic tickRise
);

    logic tickQ;

    always_ff @(posedge pulseClk or negedge rst_n) begin
        if (!rst_n) begin
            tickQ <= 1'b0;
        end else begin
            tickQ <= tickIn;
        end
    end

    assign tickRise = tickIn & ~tickQ;

endmodule

// File: rtl/ms_tick_countdown.sv
// Millisecond countdown driven by the 1 ms tick: load, pause, abort, done pulse.
// Build option MS_TICK_AUTO_RELOAD_EN makes the timer repeat until aborted.
module ms_tick_countdown
    import ms_timer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             pulseClk,
    input  logic             rst_n,
    input  logic             tickIn,
    input  logic             start,
    input  logic [CNT_W-1:0] loadValue,
    input  logic             pause,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining,
    output logic             LED
);

    state_t           state, stateNext;
    logic [CNT_W-1:0] remNext;
    logic             busyNext;
    logic             doneNext;
    logic             tickRise;

`ifdef MS_TICK_AUTO_RELOAD_EN
    logic [CNT_W-1:0] reloadReg, reloadNext;
`endif

    tick_edge_detect u_tick_edge (
        .pulseClk (pulseClk),
        .rst_n    (rst_n),
        .tickIn   (tickIn),
        .tickRise (tickRise)
    );

    always_ff @(posedge pulseClk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef MS_TICK_AUTO_RELOAD_EN
            reloadReg <= '0;
`endif
        end else begin
            state     <= stateNext;
            remaining <= remNext;
            busy      <= busyNext;
            done      <= doneNext;
`ifdef MS_TICK_AUTO_RELOAD_EN
            reloadReg <= reloadNext;
`endif
        end
    end

    // Priority within each state: abort > start > pause > tickRise.
    always_comb begin
        stateNext = state;
        remNext   = remaining;
        busyNext  = busy;
        doneNext  = 1'b0;
`ifdef MS_TICK_AUTO_RELOAD_EN
        reloadNext = reloadReg;
`endif
        case (state)
            ST_IDLE: begin
                if (!abort && start) begin
                    if (loadValue != '0) begin
                        stateNext = ST_RUN;
                        remNext   = loadValue;
                        busyNext  = 1'b1;
`ifdef MS_TICK_AUTO_RELOAD_EN
                        reloadNext = loadValue;
`endif
                    end else begin
                        doneNext = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    stateNext = ST_IDLE;
                    remNext   = '0;
                    busyNext  = 1'b0;
                end else if (pause) begin
                    stateNext = ST_PAUSED;
                end else if (tickRise) begin
                    if (remaining > CNT_W'(1)) begin
                        remNext = remaining - CNT_W'(1);
                    end else if (remaining == CNT_W'(1)) begin
                        doneNext = 1'b1;
`ifdef MS_TICK_AUTO_RELOAD_EN
                        remNext  = reloadReg;
`else
                        stateNext = ST_IDLE;
                        remNext   = '0;
                        busyNext  = 1'b0;
`endif
                    end
                end
            end
            ST_PAUSED: begin
                if (abort) begin
                    stateNext = ST_IDLE;
                    remNext   = '0;
                    busyNext  = 1'b0;
                end else if (!pause) begin
                    stateNext = ST_RUN;
                end
            end
            default: begin
                stateNext = ST_IDLE;
                remNext   = '0;
                busyNext  = 1'b0;
            end
        endcase
    end

    assign LED = busy;

endmodule

// File: tb/tb_ms_tick_countdown.sv
// Scoreboard bench for ms_tick_countdown: stimulus queues expected outputs,
// a monitor compares them one cycle later. Honours MS_TICK_AUTO_RELOAD_EN.
`timescale 1ns/1ps
module tb_ms_tick_countdown;

    logic        pulseClk;
    logic        rst_n;
    logic        tickIn;
    logic        start;
    logic [15:0] loadValue;
    logic        pause;
    logic        abort;
    logic        busy;
    logic        done;
    logic [15:0] remaining;
    logic        LED;

    int unsigned nChecks;
    int unsigned nErrors;

    logic [18:0] expQ[$];
    string       nameQ[$];

    ms_tick_countdown #(.CNT_W(16)) dut (
        .pulseClk  (pulseClk),
        .rst_n     (rst_n),
        .tickIn    (tickIn),
        .start     (start),
        .loadValue (loadValue),
        .pause     (pause),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .remaining (remaining),
        .LED       (LED)
    );

    initial pulseClk = 1'b0;
    always #5 pulseClk = ~pulseClk;

    // Packed as {LED, busy, done, remaining}.
    task automatic chk(input string name, input logic [18:0] act, input logic [18:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got led=%b busy=%b done=%b rem=%0d, want led=%b busy=%b done=%b rem=%0d",
                     name, act[18], act[17], act[16], act[15:0],
                     exp[18], exp[17], exp[16], exp[15:0]);
        end
    endtask

    always @(posedge pulseClk) begin
        #1;
        if (expQ.size() > 0) begin
            chk(nameQ.pop_front(), {LED, busy, done, remaining}, expQ.pop_front());
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input string name, input logic t, input logic s, input logic p,
                       input logic a, input logic [15:0] lv,
                       input logic eb, input logic ed, input logic [15:0] er);
        tickIn    = t;
        start     = s;
        pause     = p;
        abort     = a;
        loadValue = lv;
        expQ.push_back({eb, eb, ed, er});
        nameQ.push_back(name);
        @(posedge pulseClk);
        #2;
    endtask

    initial begin
        nChecks = 0;
        nErrors = 0;
        rst_n = 1'b0;
        tickIn = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0; loadValue = '0;
        #12;
        chk("reset_state", {LED, busy, done, remaining}, 19'd0);
        rst_n = 1'b1;

`ifndef MS_TICK_AUTO_RELOAD_EN
        // 1: three single-cycle ticks
        cyc("t1_load",  0, 1, 0, 0, 16'd3, 1, 0, 16'd3);
        cyc("t1_tick1", 1, 0, 0, 0, 16'd0, 1, 0, 16'd2);
        cyc("t1_gap1",  0, 0, 0, 0, 16'd0, 1, 0, 16'd2);
        cyc("t1_tick2", 1, 0, 0, 0, 16'd0, 1, 0, 16'd1);
        cyc("t1_gap2",  0, 0, 0, 0, 16'd0, 1, 0, 16'd1);
        cyc("t1_tick3", 1, 0, 0, 0, 16'd0, 0, 1, 16'd0);
        cyc("t1_after", 0, 0, 0, 0, 16'd0, 0, 0, 16'd0);

        // 2: ticks held high two cycles count once
        cyc("t2_load",  0, 1, 0, 0, 16'd2, 1, 0, 16'd2);
        cyc("t2_t1a",   1, 0, 0, 0, 16'd0, 1, 0, 16'd1);
        cyc("t2_t1b",   1, 0, 0, 0, 16'd0, 1, 0, 16'd1);
        cyc("t2_gap",   0, 0, 0, 0, 16'd0, 1, 0, 16'd1);
        cyc("t2_t2a",   1, 0, 0, 0, 16'd0, 0, 1, 16'd0);
        cyc("t2_t2b",   1, 0, 0, 0, 16'd0, 0, 0, 16'd0);
        cyc("t2_after", 0, 0, 0, 0, 16'd0, 0, 0, 16'd0);

        // 3: pause holds the count; tick coincident with pause is dropped
        cyc("t3_load",  0, 1, 0, 0, 16'd5, 1, 0, 16'd5);
        cyc("t3_tick1", 1, 0, 0, 0, 16'd0, 1, 0, 16'd4);
        cyc("t3_gap1",  0, 0, 0, 0, 16'd0, 1, 0, 16'd4);
        cyc("t3_tick2", 1, 0, 0, 0, 16'd0, 1, 0, 16'd3);
        cyc("t3_gap2",  0, 0, 0, 0, 16'd0, 1, 0, 16'd3);
        cyc("t3_pause", 1, 0, 1, 0, 16'd0, 1, 0, 16'd3);
        for (int i = 0; i < 3; i++) begin
            cyc("t3_p_gap",  0, 0, 1, 0, 16'd0, 1, 0, 16'd3);
            cyc("t3_p_tick", 1, 0, 1, 0, 16'd0, 1, 0, 16'd3);
        end
        cyc("t3_p_last",  0, 0, 1, 0, 16'd0, 1, 0, 16'd3);
        cyc("t3_release", 0, 0, 0, 0, 16'd0, 1, 0, 16'd3);
        cyc("t3_tick3",   1, 0, 0, 0, 16'd0, 1, 0, 16'd2);
        cyc("t3_gap3",    0, 0, 0, 0, 16'd0, 1, 0, 16'd2);
        cyc("t3_tick4",   1, 0, 0, 0, 16'd0, 1, 0, 16'd1);
        cyc("t3_gap4",    0, 0, 0, 0, 16'd0, 1, 0, 16'd1);
        cyc("t3_tick5",   1, 0, 0, 0, 16'd0, 0, 1, 16'd0);
        cyc("t3_after",   0, 0, 0, 0, 16'd0, 0, 0, 16'd0);
`endif

        // 4: abort after one tick; coincident start ignored; idle ticks inert
        cyc("t4_load",  0, 1, 0, 0, 16'd4, 1, 0, 16'd4);
        cyc("t4_tick1", 1, 0, 0, 0, 16'd0, 1, 0, 16'd3);
        cyc("t4_gap",   0, 0, 0, 0, 16'd0, 1, 0, 16'd3);
        cyc("t4_abort", 0, 1, 0, 1, 16'd9, 0, 0, 16'd0);
        cyc("t4_idle1", 0, 0, 0, 0, 16'd0, 0, 0, 16'd0);
        cyc("t4_itick", 1, 0, 0, 0, 16'd0, 0, 0, 16'd0);
        cyc("t4_idle2", 0, 0, 0, 0, 16'd0, 0, 0, 16'd0);

        // 5: zero-length timeout; tick with start not counted; no restart while busy
        cyc("t5_zero",    0, 1, 0, 0, 16'd0, 0, 1, 16'd0);
        cyc("t5_zero_nx", 0, 0, 0, 0, 16'd0, 0, 0, 16'd0);
        cyc("t5_load",    1, 1, 0, 0, 16'd6, 1, 0, 16'd6);
        cyc("t5_restart", 0, 1, 0, 0, 16'd2, 1, 0, 16'd6);
        cyc("t5_tick1",   1, 0, 0, 0, 16'd0, 1, 0, 16'd5);
        cyc("t5_gap",     0, 0, 0, 0, 16'd0, 1, 0, 16'd5);
        cyc("t5_abort",   0, 0, 0, 1, 16'd0, 0, 0, 16'd0);

`ifdef MS_TICK_AUTO_RELOAD_EN
        // reload: done every 2 ticks, remaining reloads to 2
        cyc("r_load",   0, 1, 0, 0, 16'd2, 1, 0, 16'd2);
        cyc("r_tick1",  1, 0, 0, 0, 16'd0, 1, 0, 16'd1);
        cyc("r_gap1",   0, 0, 0, 0, 16'd0, 1, 0, 16'd1);
        cyc("r_exp1",   1, 0, 0, 0, 16'd0, 1, 1, 16'd2);
        cyc("r_gap2",   0, 0, 0, 0, 16'd0, 1, 0, 16'd2);
        cyc("r_tick3",  1, 0, 0, 0, 16'd0, 1, 0, 16'd1);
        cyc("r_gap3",   0, 0, 0, 0, 16'd0, 1, 0, 16'd1);
        cyc("r_exp2",   1, 0, 0, 0, 16'd0, 1, 1, 16'd2);
        cyc("r_abort",  0, 0, 0, 1, 16'd0, 0, 0, 16'd0);
`endif

        // 6: asynchronous reset mid-count
        cyc("t6_load",  0, 1, 0, 0, 16'd7, 1, 0, 16'd7);
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset", {LED, busy, done, remaining}, 19'd0);
        cyc("t6_held",  1, 0, 0, 0, 16'd0, 0, 0, 16'd0);
        rst_n = 1'b1;
        cyc("t6_post1", 0, 0, 0, 0, 16'd0, 0, 0, 16'd0);
        cyc("t6_post2", 1, 0, 0, 0, 16'd0, 0, 0, 16'd0);

        chk("scoreboard_drained", {3'b000, 16'(expQ.size())}, 19'd0);
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
